sprite_compositor: RTL
======================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameters, one per line: SPR_W, 16, sprite width in pixels; SPR_H, 8, sprite height in pixels; BG_RGB, 12'h001, background colour; BULLET_H, 4, bullet height in pixels (bullet is 1 pixel wide).
REQ-002 clk  input  1  pixel clock (25 MHz); one clock domain only.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sx, sy  input  10 each  pixel position from the VGA timer.
REQ-005 de, hsync, vsync  input  1 each  timer strobes, aligned with sx/sy.
REQ-006 pos_valid / pos_ready  input / output  1 / 1  position-update handshake.
REQ-007 player_x, alien_x, alien_y, bullet_x, bullet_y  input  10 each  requested positions; qualified by pos_valid.
REQ-008 bullet_en  input  1  bullet visible; qualified by pos_valid.
REQ-009 rgb  output  12  pixel colour, 4:4:4.
REQ-010 de_o, hsync_o, vsync_o  output  1 each  strobes delayed to match rgb.
REQ-011 hit  output  1  one-cycle collision pulse (COLLISION_EN only; otherwise tied 0).

Function
REQ-012 Pipeline latency is exactly 2 clocks: rgb, de_o, hsync_o and vsync_o for pixel (sx,sy) appear 2 cycles after sx/sy are presented.
REQ-013 Positions are held in two banks. The pending bank is written by the handshake; the active bank drives drawing.
REQ-014 pos_ready is 1 when the pending bank is empty. A transfer occurs when pos_valid and pos_ready are both 1 on a rising edge.
REQ-015 After a transfer the pending bank is full and pos_ready is 0 until the pending bank is promoted.
REQ-016 Promotion happens on the cycle with sx==0 and sy==480, the first blanking line. Pending is copied to active and pos_ready returns to 1 on the next cycle.
REQ-017 A transfer and a promotion in the same cycle: the promotion uses the previous pending contents, and the new data stays pending.
REQ-018 Active positions never change while sy<480, so there is no tearing.
REQ-019 Player sprite occupies x in [player_x, player_x+SPR_W-1] and y in [464, 464+SPR_H-1]. It uses ROM bitmap 0.
REQ-020 Alien sprite occupies [alien_x, alien_x+SPR_W-1] by [alien_y, alien_y+SPR_H-1]. It uses ROM bitmap 1.
REQ-021 Bullet occupies x==bullet_x and y in [bullet_y, bullet_y+BULLET_H-1], and only when bullet_en=1.
REQ-022 Range comparisons use 11-bit arithmetic. A sprite extending past x=639 or y=479 is clipped and never wraps.
REQ-023 Pixel priority: bullet (12'hFFF) over player (12'h0F0) over alien (12'hF0F) over BG_RGB. A sprite contributes only where its ROM bit is 1.
REQ-024 rgb is 12'h000 whenever the delayed de is 0.

Reset
REQ-025 While rst_n=0: rgb=0, de_o=0, hsync_o=1, vsync_o=1, hit=0, pos_ready=1, both banks zero, bullet_en inactive.
REQ-026 Reset deassertion mid-frame: the first 2 output cycles carry reset values, then normal pipelined output follows.
REQ-027 A pending update in flight when reset asserts is discarded.

Configuration
REQ-028 Macro SPRITE_COLLISION_EN.
REQ-029 With the macro defined: a sticky per-frame flag sets when, at one pixel with delayed de=1, the bullet and an opaque alien ROM bit coincide. hit pulses for 1 cycle at the first such pixel of each frame. The flag clears at promotion (sx==0, sy==480).
REQ-030 Without the macro: no flag logic exists and hit is constant 0.

Structure
REQ-031 Shared package vga_pkg holds H_ACTIVE=640, V_ACTIVE=480, VBLANK_LINE=480, PLAYER_Y=464, the colour constants and the rgb12 typedef.
REQ-032 One sub-module, sprite_rom: synchronous read, 1-cycle latency, address {bitmap_sel, row[2:0]}, 16-bit row output. It forms pipeline stage 2.
REQ-033 Stage 1 registers hit tests, row/column offsets and the delayed strobes. Stage 2 does the ROM lookup and colour mux.

Verification
REQ-034 Reset: hold rst_n=0 for 5 cycles -> rgb=0, hsync_o=1, vsync_o=1, pos_ready=1, hit=0.
REQ-035 Latency: drive hsync falling at sx=656 -> hsync_o falls exactly 2 cycles later. de_o tracks de the same way.
REQ-036 Handshake: send player_x=100 at sy=200 -> pos_ready=0 until the cycle after sx=0, sy=480. Rows 464-471 of the current frame still draw at the old x; the next frame draws at x=100.
REQ-037 Clipping: alien_x=632 -> only columns 632-639 are drawn; column 0 of the next line is BG_RGB.
REQ-038 Priority and collision: bullet_x=alien_x+3, bullet_y=alien_y, with the ROM bit set -> the pixel is 12'hFFF and hit pulses once per frame (macro on) or never (macro off).
REQ-039 Simultaneous events: pos_valid high on the promotion cycle -> the new data is promoted one frame later, and pos_ready stays 0 until then.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type, position bank record and a span-test helper
// used by the sprite compositor.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE    = 10'd640;
    localparam logic [9:0] V_ACTIVE    = 10'd480;
    localparam logic [9:0] VBLANK_LINE = 10'd480;
    localparam logic [9:0] PLAYER_Y    = 10'd464;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t COL_BLACK  = 12'h000;
    localparam rgb12_t COL_BULLET = 12'hFFF;
    localparam rgb12_t COL_PLAYER = 12'h0F0;
    localparam rgb12_t COL_ALIEN  = 12'hF0F;

    typedef struct packed {
        logic [9:0] player_x;
        logic [9:0] alien_x;
        logic [9:0] alien_y;
        logic [9:0] bullet_x;
        logic [9:0] bullet_y;
        logic       bullet_en;
    } pos_t;

    // True when p lies in [lo, lo+len-1]; 11-bit maths so spans near 1023 never wrap to 0.
    function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo,
                                     input logic [10:0] len);
        logic [10:0] off;
        off = {1'b0, p} - {1'b0, lo};
        return ({1'b0, p} >= {1'b0, lo}) && (off < len);
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap ROM: bitmap 0 = player, bitmap 1 = alien; one 16-bit row per
// address, registered read (1-cycle latency). Bit 15 is the leftmost column.
module sprite_rom (
    input  logic        clk,
    input  logic        bitmap_sel,
    input  logic [2:0]  row,
    output logic [15:0] data
);

    logic [3:0]  addr;
    logic [15:0] rom_word;

    assign addr = {bitmap_sel, row};

    always_comb begin
        // NOTE: default first so every path assigns rom_word and no latch is inferred.
        rom_word = '0;
        case (addr)
            4'h0: rom_word = 16'h0180;
            4'h1: rom_word = 16'h03C0;
            4'h2: rom_word = 16'h07E0;
            4'h3: rom_word = 16'h7FFE;
            4'h4: rom_word = 16'hFFFF;
            4'h5: rom_word = 16'hFFFF;
            4'h6: rom_word = 16'hFFFF;
            4'h7: rom_word = 16'hFFFF;
            4'h8: rom_word = 16'h1FF8;
            4'h9: rom_word = 16'h3FFC;
            4'hA: rom_word = 16'h6DB6;
            4'hB: rom_word = 16'hFFFF;
            4'hC: rom_word = 16'hFFFF;
            4'hD: rom_word = 16'h2424;
            4'hE: rom_word = 16'h4812;
            4'hF: rom_word = 16'h8001;
            default: rom_word = '0;
        endcase
    end

    // NOTE: memory read register is not reset; its value is only used when the
    // reset-cleared sprite flags in the next stage select it.
    always_ff @(posedge clk) begin
        data <= rom_word;
    end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: double-banked positions, span tests, ROM lookup
// and priority colour mux. Optional collision flag under SPRITE_COLLISION_EN.
module sprite_compositor
    import vga_pkg::*;
#(
    parameter int     SPR_W    = 16,
    parameter int     SPR_H    = 8,
    parameter rgb12_t BG_RGB   = 12'h001,
    parameter int     BULLET_H = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       pos_valid,
    output logic       pos_ready,
    input  logic [9:0] player_x,
    input  logic [9:0] alien_x,
    input  logic [9:0] alien_y,
    input  logic [9:0] bullet_x,
    input  logic [9:0] bullet_y,
    input  logic       bullet_en,
    output rgb12_t     rgb,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       hit
);

    localparam logic [10:0] W_SPAN = 11'(SPR_W);
    localparam logic [10:0] H_SPAN = 11'(SPR_H);
    localparam logic [10:0] B_SPAN = 11'(BULLET_H);

    pos_t pend, act;
    logic pend_full, promote, xfer;

    assign promote   = (sx == 10'd0) && (sy == VBLANK_LINE);
    assign xfer      = pos_valid && !pend_full;
    assign pos_ready = !pend_full;

    // Active bank only changes on the first blanking line, so drawing never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            act       <= '0;
            pend_full <= 1'b0;
        end else begin
            if (promote && pend_full) begin
                act       <= pend;
                pend_full <= 1'b0;
            end
            if (xfer) begin
                pend      <= '{player_x: player_x, alien_x: alien_x, alien_y: alien_y,
                               bullet_x: bullet_x, bullet_y: bullet_y, bullet_en: bullet_en};
                pend_full <= 1'b1;
            end
        end
    end

    logic on_screen, player_c, alien_c, bullet_c;
    assign on_screen = (sx < H_ACTIVE) && (sy < V_ACTIVE);
    assign player_c  = on_screen && in_span(sx, act.player_x, W_SPAN) && in_span(sy, PLAYER_Y, H_SPAN);
    assign alien_c   = on_screen && in_span(sx, act.alien_x, W_SPAN) && in_span(sy, act.alien_y, H_SPAN);
    assign bullet_c  = on_screen && act.bullet_en && (sx == act.bullet_x)
                       && in_span(sy, act.bullet_y, B_SPAN);

    logic       s1_player, s1_alien, s1_bullet, s1_de, s1_hs, s1_vs;
    logic [3:0] s1_pcol, s1_acol;
    logic [2:0] s1_prow, s1_arow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_player <= 1'b0;
            s1_alien  <= 1'b0;
            s1_bullet <= 1'b0;
            s1_pcol   <= '0;
            s1_acol   <= '0;
            s1_prow   <= '0;
            s1_arow   <= '0;
            s1_de     <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
        end else begin
            s1_player <= player_c;
            s1_alien  <= alien_c;
            s1_bullet <= bullet_c;
            s1_pcol   <= 4'(sx - act.player_x);
            s1_acol   <= 4'(sx - act.alien_x);
            s1_prow   <= 3'(sy - PLAYER_Y);
            s1_arow   <= 3'(sy - act.alien_y);
            s1_de     <= de;
            s1_hs     <= hsync;
            s1_vs     <= vsync;
        end
    end

    logic [15:0] p_bits, a_bits;

    sprite_rom u_player_rom (.clk(clk), .bitmap_sel(1'b0), .row(s1_prow), .data(p_bits));
    sprite_rom u_alien_rom  (.clk(clk), .bitmap_sel(1'b1), .row(s1_arow), .data(a_bits));

    logic       s2_player, s2_alien, s2_bullet;
    logic [3:0] s2_pcol, s2_acol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_player <= 1'b0;
            s2_alien  <= 1'b0;
            s2_bullet <= 1'b0;
            s2_pcol   <= '0;
            s2_acol   <= '0;
            de_o      <= 1'b0;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
        end else begin
            s2_player <= s1_player;
            s2_alien  <= s1_alien;
            s2_bullet <= s1_bullet;
            s2_pcol   <= s1_pcol;
            s2_acol   <= s1_acol;
            de_o      <= s1_de;
            hsync_o   <= s1_hs;
            vsync_o   <= s1_vs;
        end
    end

    logic player_px, alien_px;
    assign player_px = s2_player && p_bits[4'd15 - s2_pcol];
    assign alien_px  = s2_alien && a_bits[4'd15 - s2_acol];

    always_comb begin
        rgb = COL_BLACK;
        if (de_o) begin
            if (s2_bullet)      rgb = COL_BULLET;
            else if (player_px) rgb = COL_PLAYER;
            else if (alien_px)  rgb = COL_ALIEN;
            else                rgb = BG_RGB;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic hit_flag, coincide;
    assign coincide = de_o && s2_bullet && alien_px;
    assign hit      = coincide && !hit_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        hit_flag <= 1'b0;
        else if (promote)  hit_flag <= 1'b0;
        else if (coincide) hit_flag <= 1'b1;
    end
`else
    assign hit = 1'b0;
`endif

endmodule
